// File: rtl/weight_pkg.sv
// Shared constants, FIFO entry layout and channel packing helper for the
// multi-channel weight read path.
package weight_pkg;

    localparam int MAX_WEIGHT_ROMS = 3;
    localparam int W_DATA_DEF      = 3;
    localparam int N_CH_DEF        = 3;

    typedef struct packed {
        logic                             err;
        logic [N_CH_DEF*W_DATA_DEF-1:0]   data;
    } wentry_t;

    function automatic int ch_slice(input int ch, input int w_data);
        return ch * w_data;
    endfunction

endpackage

// File: rtl/weight_ofifo.sv
// Output FIFO for packed weight words; pointers wrap modulo DEPTH so any
// depth >= 2 works. Caller never pushes when full nor pops when empty.
module weight_ofifo #(
    parameter  int W     = 10,
    parameter  int DEPTH = 3,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [W-1:0]     wdata_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_o,
    output logic [OCC_W-1:0] occ_o
);
    if (DEPTH < 2) begin : g_depth_err
        $error("weight_ofifo: DEPTH must be at least 2");
    end

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (push_i) wr_d = wrap_inc(wr_q);
        if (pop_i)  rd_d = wrap_inc(rd_q);
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    assign head_o = mem_q[rd_q];
    assign occ_o  = occ_q;
endmodule

// File: rtl/weight_roms.sv
// Weight ROM images, one module per bank; each registers its word one cycle
// after en_i. Contents are fixed closed-form patterns of the address.
module weights0_rom #(
    parameter int W_DATA = 3,
    parameter int W_ADDR = 12
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [W_ADDR-1:0] addr_i,
    output logic [W_DATA-1:0] q_o
);
    logic [W_DATA-1:0] word;
    logic [W_DATA-1:0] rom_q;

    // Bit j is the parity of every address bit k with k mod W_DATA == j.
    always_comb begin
        word = '0;
        for (int k = 0; k < W_ADDR; k++) begin
            word[k % W_DATA] = word[k % W_DATA] ^ addr_i[k];
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) rom_q <= word;
    end

    assign q_o = rom_q;
endmodule

module weights1_rom #(
    parameter int W_DATA = 3,
    parameter int W_ADDR = 12
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [W_ADDR-1:0] addr_i,
    output logic [W_DATA-1:0] q_o
);
    logic [W_DATA-1:0] rom_q;

    always_ff @(posedge clk) begin
        if (en_i) rom_q <= W_DATA'(addr_i + (addr_i >> 3));
    end

    assign q_o = rom_q;
endmodule

module weights2_rom #(
    parameter int W_DATA = 3,
    parameter int W_ADDR = 12
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [W_ADDR-1:0] addr_i,
    output logic [W_DATA-1:0] q_o
);
    logic [W_DATA-1:0] rom_q;

    always_ff @(posedge clk) begin
        if (en_i) rom_q <= W_DATA'((addr_i >> 1) + W_ADDR'(5));
    end

    assign q_o = rom_q;
endmodule

// File: rtl/weight_bank_rd.sv
// Lock-step read of N_CH weight ROMs from one address stream, returned as one
// packed word per address through a credit-limited output FIFO.
module weight_bank_rd
    import weight_pkg::*;
#(
    parameter int W_DATA      = 3,
    parameter int W_ADDR      = 12,
    parameter int N_CH        = 3,
    parameter int WEIGHT_BASE = 0,
    parameter int N_ENTRIES   = 4096,
    parameter int FIFO_DEPTH  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   addr_valid,
    output logic                   addr_ready,
    input  logic [W_ADDR-1:0]      addr_data,
    output logic                   data_valid,
    input  logic                   data_ready,
    output logic [N_CH*W_DATA-1:0] data,
    output logic                   data_err
);
    localparam int DW    = N_CH * W_DATA;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [W_ADDR:0] ADDR_LIMIT = (W_ADDR + 1)'(N_ENTRIES);
    localparam logic [OCC_W:0]  CREDITS    = (OCC_W + 1)'(FIFO_DEPTH);

    if (N_CH < 1 || N_CH > MAX_WEIGHT_ROMS || WEIGHT_BASE < 0 ||
        WEIGHT_BASE + N_CH > MAX_WEIGHT_ROMS) begin : g_cfg_err
        $error("weight_bank_rd: N_CH/WEIGHT_BASE select a weight ROM that does not exist");
    end

    logic              fire_a, pop;
    logic              inflight_q, inflight_d;
    logic              err_q, err_d;
    logic [DW-1:0]     rom_word;
    logic [DW:0]       push_ent, head;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    credits_used;

    // Credit counts the word still inside the ROM so the push one cycle later
    // always finds a free slot; built from registers only.
    assign credits_used = {1'b0, occ} + (OCC_W + 1)'(inflight_q);
    assign addr_ready   = rst && (credits_used < CREDITS);
    assign fire_a       = addr_valid && addr_ready;

    always_comb begin
        inflight_d = fire_a;
        err_d      = ({1'b0, addr_data} >= ADDR_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) inflight_q <= 1'b0;
        else      inflight_q <= inflight_d;
    end

    always_ff @(posedge clk) begin
        if (fire_a) err_q <= err_d;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        localparam int ROM_ID = WEIGHT_BASE + i;
        logic [W_DATA-1:0] q;
        if (ROM_ID == 0) begin : g_rom0
            weights0_rom #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) u_rom (
                .clk(clk), .en_i(fire_a), .addr_i(addr_data), .q_o(q));
        end else if (ROM_ID == 1) begin : g_rom1
            weights1_rom #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) u_rom (
                .clk(clk), .en_i(fire_a), .addr_i(addr_data), .q_o(q));
        end else begin : g_rom2
            weights2_rom #(.W_DATA(W_DATA), .W_ADDR(W_ADDR)) u_rom (
                .clk(clk), .en_i(fire_a), .addr_i(addr_data), .q_o(q));
        end
        assign rom_word[ch_slice(i, W_DATA) +: W_DATA] = q;
    end

    assign push_ent = {err_q, err_q ? {DW{1'b0}} : rom_word};

    weight_ofifo #(.W(DW + 1), .DEPTH(FIFO_DEPTH)) u_ofifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (inflight_q),
        .wdata_i(push_ent),
        .pop_i  (pop),
        .head_o (head),
        .occ_o  (occ)
    );

    assign data_valid = rst && (occ != '0);
    assign pop        = data_valid && data_ready;
    assign data       = data_valid ? head[DW-1:0] : {DW{1'b0}};
    assign data_err   = data_valid && head[DW];
endmodule

// File: tb/tb_weight_bank_rd.sv
// Scoreboard bench for weight_bank_rd: accepted addresses queue their expected
// word, an independent monitor pops and compares every word the DUT hands out.
module tb_weight_bank_rd;
    import weight_pkg::*;

    localparam int W_DATA     = 3;
    localparam int W_ADDR     = 12;
    localparam int N_CH       = 3;
    localparam int N_ENTRIES  = 100;
    localparam int FIFO_DEPTH = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   addr_valid = 1'b0;
    logic                   addr_ready;
    logic [W_ADDR-1:0]      addr_data = '0;
    logic                   data_valid;
    logic                   data_ready = 1'b0;
    logic [N_CH*W_DATA-1:0] data;
    logic                   data_err;

    wentry_t exp_next;
    wentry_t sb_q[$];
    wentry_t hold_e;
    logic    hold_v = 1'b0;
    int      n_cmp = 0;
    int      n_bad = 0;
    int      acc_cnt = 0;
    int      pop_cnt = 0;

    always #5 clk = ~clk;

    weight_bank_rd #(
        .W_DATA(W_DATA), .W_ADDR(W_ADDR), .N_CH(N_CH), .WEIGHT_BASE(0),
        .N_ENTRIES(N_ENTRIES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_data(addr_data),
        .data_valid(data_valid), .data_ready(data_ready),
        .data(data), .data_err(data_err)
    );

    // Reference ROM contents written independently of the RTL formulation.
    function automatic wentry_t model(input int a);
        wentry_t e;
        int c0, c1, c2;
        e = '0;
        if (a >= N_ENTRIES) begin
            e.err = 1'b1;
            return e;
        end
        c0 = (a % 8) ^ ((a / 8) % 8) ^ ((a / 64) % 8) ^ ((a / 512) % 8);
        c1 = (a + a / 8) % 8;
        c2 = (a / 2 + 5) % 8;
        e.data = 9'(c2 * 64 + c1 * 8 + c0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic monitor_loop();
        wentry_t got, e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_v = 1'b0;
            end else begin
                got = {data_err, data};
                if (hold_v)
                    check("hold_stable", 32'({data_valid, got}), 32'({1'b1, hold_e}));
                if (data_valid && data_ready) begin
                    pop_cnt++;
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %0h, expected no word (t=%0t)", got, $time);
                    end else begin
                        e = sb_q.pop_front();
                        check("word", 32'(got), 32'(e));
                    end
                end
                hold_v = data_valid && !data_ready;
                hold_e = got;
            end
        end
    endtask

    task automatic tracker_loop();
        forever begin
            @(negedge clk);
            if (rst && addr_valid && addr_ready) begin
                sb_q.push_back(exp_next);
                acc_cnt++;
            end
        end
    endtask

    task automatic send(input logic [W_ADDR-1:0] a, input wentry_t e);
        int guard;
        @(posedge clk); #1;
        addr_valid = 1'b1;
        addr_data  = a;
        exp_next   = e;
        @(negedge clk);
        guard = 0;
        while (!addr_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!addr_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: addr %0d, addr_ready %0b, expected 1", a, addr_ready);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        addr_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        @(negedge clk); #1;
        while ((sb_q.size() != 0 || data_valid) && n < max_cyc) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain_left", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic run_tests();
        logic [W_ADDR-1:0] a;
        logic              took;
        int                base, cnt, guard;

        // Reset held with an address on offer.
        rst = 1'b0; addr_valid = 1'b1; addr_data = 12'd7; exp_next = model(7);
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            check("rst_data_valid", 32'(data_valid), 32'd0);
            check("rst_addr_ready", 32'(addr_ready), 32'd0);
            check("rst_data", 32'({data_err, data}), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1; addr_valid = 1'b0;
        @(negedge clk);
        check("release_addr_ready", 32'(addr_ready), 32'd1);
        check("release_no_output", 32'(data_valid), 32'd0);

        // Back-to-back stream 0..99.
        data_ready = 1'b1;
        base = pop_cnt;
        for (int i = 0; i < 100; i++) begin
            send(12'(i), model(i));
            if (i == 1) check("latency_not_early", 32'(data_valid), 32'd0);
            if (i == 2) check("latency_first_word", 32'(data_valid), 32'd1);
        end
        idle();
        @(negedge clk); @(negedge clk); #1;
        check("stream_one_per_cycle", 32'(pop_cnt - base), 32'd100);
        drain(20);

        // Backpressure: only FIFO_DEPTH addresses may be taken.
        data_ready = 1'b0;
        base = acc_cnt;
        @(posedge clk); #1;
        a = 12'd10; addr_valid = 1'b1; addr_data = a; exp_next = model(10);
        repeat (8) begin
            @(negedge clk);
            took = addr_ready;
            @(posedge clk); #1;
            if (took) begin
                a = a + 1'b1;
                addr_data = a;
                exp_next = model(int'(a));
            end
        end
        addr_valid = 1'b0;
        check("bp_accepted", 32'(acc_cnt - base), 32'(FIFO_DEPTH));
        @(negedge clk);
        check("bp_addr_ready_low", 32'(addr_ready), 32'd0);
        check("bp_head_word", 32'({data_valid, data_err, data}), 32'({1'b1, model(10)}));
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        data_ready = 1'b1;
        drain(20);

        // Random valid/ready traffic.
        cnt = 0; guard = 0; took = 1'b0;
        while (cnt < 10000 && guard < 60000) begin
            @(posedge clk); #1;
            guard++;
            if (!addr_valid || took) begin
                addr_valid = ($urandom_range(0, 9) < 7);
                a = 12'($urandom_range(0, 127));
                addr_data = a;
                exp_next = model(int'(a));
            end
            data_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            took = addr_valid && addr_ready;
            if (took) cnt++;
        end
        idle();
        data_ready = 1'b1;
        check("random_accepted", 32'(cnt), 32'd10000);
        drain(50);

        // Range boundary with hand-computed words {err, ch2, ch1, ch0}.
        send(12'd99,   wentry_t'(10'h1BE));
        send(12'd100,  wentry_t'(10'h200));
        send(12'd4095, wentry_t'(10'h200));
        send(12'd0,    wentry_t'(10'h140));
        idle();
        drain(20);

        // Reset with two words buffered and one in the ROM stage.
        data_ready = 1'b0;
        send(12'd20, model(20));
        send(12'd21, model(21));
        send(12'd22, model(22));
        @(posedge clk); #1;
        rst = 1'b0; addr_valid = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b1; data_ready = 1'b1;
        addr_valid = 1'b1; addr_data = 12'd5; exp_next = wentry_t'(10'h1ED);
        @(negedge clk);
        check("midrst_empty", 32'({data_valid, data_err, data}), 32'd0);
        check("midrst_addr_ready", 32'(addr_ready), 32'd1);
        @(posedge clk); #1;
        addr_valid = 1'b0;
        @(negedge clk);
        check("midrst_lat1", 32'(data_valid), 32'd0);
        @(negedge clk);
        check("midrst_rom5", 32'({data_valid, data_err, data}), 32'({1'b1, 10'h1ED}));
        drain(20);
    endtask

    initial begin
        fork
            monitor_loop();
            tracker_loop();
            run_tests();
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
